// File: rtl/dmem_arbiter_pkg.sv
// Shared definitions for the two-port data-memory arbiter: FSM encoding,
// port identifiers and default geometry.
package dmem_arbiter_pkg;

    localparam int unsigned DEF_WIDTH = 32;
    localparam int unsigned DEF_DEPTH = 128;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    localparam logic PORT0 = 1'b0;
    localparam logic PORT1 = 1'b1;

endpackage

// File: rtl/dmem_arbiter_rr_arb2.sv
// Two-input round-robin arbiter: on a tie the port that did not win last
// time is granted; a lone requester always wins.
module rr_arb2
    import dmem_arbiter_pkg::*;
(
    input  logic [1:0] i_req,
    input  logic       i_last_grant,
    output logic [1:0] o_grant
);

    always_comb begin
        o_grant = '0;
        case (i_req)
            2'b01:   o_grant = 2'b01;
            2'b10:   o_grant = 2'b10;
            2'b11:   o_grant = (i_last_grant == PORT1) ? 2'b01 : 2'b10;
            default: o_grant = '0;
        endcase
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Arbitrates a core port and a DMA/debug port onto one data-memory engine;
// each access takes IDLE -> ACCESS -> RESP, acking the owner in RESP.
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned DEPTH = DEF_DEPTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0,
    input  logic             req1,
    input  logic             we0,
    input  logic             we1,
    input  logic [WIDTH-1:0] addr0,
    input  logic [WIDTH-1:0] addr1,
    input  logic [WIDTH-1:0] wdata0,
    input  logic [WIDTH-1:0] wdata1,
    output logic             ack0,
    output logic             ack1,
    output logic             err0,
    output logic             err1,
    output logic [WIDTH-1:0] rdata,
    output logic             mem_read_en,
    output logic             mem_write_en,
    output logic [WIDTH-1:0] mem_addr,
    output logic [WIDTH-1:0] mem_wdata,
    input  logic [WIDTH-1:0] mem_rdata
);

    localparam logic [WIDTH-1:0] DEPTH_W = WIDTH'(DEPTH);

    state_t           r_state;
    state_t           w_state_nxt;
    logic             r_last_grant;
    logic             r_port;
    logic             r_we;
    logic             r_err;
    logic [WIDTH-1:0] r_addr;
    logic [WIDTH-1:0] r_wdata;
    logic [WIDTH-1:0] r_rdata;

    logic [1:0]       w_grant;
    logic             w_grant_port;
    logic             w_load;
    logic             w_win_we;
    logic [WIDTH-1:0] w_win_addr;
    logic [WIDTH-1:0] w_win_wdata;

    rr_arb2 u_rr_arb2 (
        .i_req        ({req1, req0}),
        .i_last_grant (r_last_grant),
        .o_grant      (w_grant)
    );

    always_comb begin
        w_grant_port = w_grant[1] ? PORT1 : PORT0;
        w_load       = (r_state == ST_IDLE) && (w_grant != 2'b00);
        w_win_we     = (w_grant_port == PORT1) ? we1    : we0;
        w_win_addr   = (w_grant_port == PORT1) ? addr1  : addr0;
        w_win_wdata  = (w_grant_port == PORT1) ? wdata1 : wdata0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Strobes and acks decode from the state register only, so an
    // asynchronous reset removes them in the same cycle.
    always_comb begin
        w_state_nxt  = r_state;
        mem_read_en  = 1'b0;
        mem_write_en = 1'b0;
        ack0         = 1'b0;
        ack1         = 1'b0;
        err0         = 1'b0;
        err1         = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_grant != 2'b00) begin
                    w_state_nxt = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                w_state_nxt = ST_RESP;
                if (!r_err) begin
                    mem_read_en  = !r_we;
                    mem_write_en = r_we;
                end
            end
            ST_RESP: begin
                w_state_nxt = ST_IDLE;
                ack0        = (r_port == PORT0);
                ack1        = (r_port == PORT1);
                err0        = (r_port == PORT0) && r_err;
                err1        = (r_port == PORT1) && r_err;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_last_grant <= PORT1;
            r_port       <= PORT0;
            r_we         <= 1'b0;
            r_err        <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_rdata      <= '0;
        end else begin
            if (w_load) begin
                r_last_grant <= w_grant_port;
                r_port       <= w_grant_port;
                r_we         <= w_win_we;
                r_err        <= (w_win_addr >= DEPTH_W);
                r_addr       <= w_win_addr;
                r_wdata      <= w_win_wdata;
            end
            if (r_state == ST_ACCESS) begin
                r_rdata <= (!r_err && !r_we) ? mem_rdata : '0;
            end
        end
    end

    assign mem_addr  = r_addr;
    assign mem_wdata = r_wdata;
    assign rdata     = r_rdata;

endmodule
